radar_echo_responder: RTL and testbench

Target-side responder for the radar pulse/echo link. Watches `radar_pulse_trigger`, waits the round-trip time matching the current target range, then returns a `radar_echo` pulse. Models a target moving at a fixed closing rate per pulse. Used as the far end of the ARTAU radar interface in system benches and FPGA loopback builds.

---
 rtl/icms_pkg.sv | 15 +
 rtl/rising_edge_detect.sv | 24 ++
 rtl/radar_echo_responder.sv | 165 ++++++++++++++++
 tb/tb_radar_echo_responder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/icms_pkg.sv
// Shared scale constants and responder state encoding for the ARTAU radar link.
// The ARTAU side imports the same package so that both ends agree on range units.
package icms_pkg;

  localparam int DIST_W          = 32;
  localparam int DEF_M_PER_CYCLE = 15000;
  localparam int DEF_MAX_RANGE   = 1000000;

  typedef enum logic [1:0] {
    RESP_IDLE   = 2'd0,
    RESP_FLIGHT = 2'd1,
    RESP_ECHO   = 2'd2
  } resp_state_t;

endpackage

// File: rtl/rising_edge_detect.sv
// One-bit rising edge detector. The previous value is registered, and the edge
// pulse is combinational: it is high in the same cycle the input goes high.
module rising_edge_detect (
  input  logic CLK,
  input  logic RST,
  input  logic sig_i,
  output logic edge_o
);

  logic prev_d, prev_q;

  always_comb begin
    prev_d = sig_i;
  end

  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) prev_q <= 1'b0;
    else     prev_q <= prev_d;
  end

  assign edge_o = sig_i & ~prev_q;

endmodule

// File: rtl/radar_echo_responder.sv
// Target-side radar responder: returns an echo one round-trip time after each
// accepted trigger, and moves the target by closing_rate after every echo.
module radar_echo_responder
  import icms_pkg::*;
#(
  parameter int M_PER_CYCLE = DEF_M_PER_CYCLE,
  parameter int MAX_RANGE   = DEF_MAX_RANGE,
  parameter int ECHO_WIDTH  = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        radar_pulse_trigger,
  input  logic        load_target,
  input  logic [31:0] target_range,
  input  logic [15:0] closing_rate,
  output logic        radar_echo,
  output logic        busy,
  output logic [31:0] current_range,
  output logic [7:0]  echo_count,
  output logic [7:0]  missed_count,
  output logic [1:0]  resp_state
);

  localparam int WCNT_W = (ECHO_WIDTH > 1) ? $clog2(ECHO_WIDTH) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(ECHO_WIDTH - 1);
  localparam logic [32:0]       M_STEP    = 33'(M_PER_CYCLE);
  localparam logic [31:0]       MAX_R     = 32'(MAX_RANGE);

  logic rise;

  rising_edge_detect u_trig_edge (
    .CLK    (CLK),
    .RST    (RST),
    .sig_i  (radar_pulse_trigger),
    .edge_o (rise)
  );

  resp_state_t        state_d, state_q;
  logic [31:0]        dist_d, dist_q;
  logic [32:0]        acc_d, acc_q;
  logic [WCNT_W-1:0]  wcnt_d, wcnt_q;
  logic               echo_d, echo_q;
  logic               busy_d, busy_q;
  logic [31:0]        range_d, range_q;
  logic [15:0]        rate_d, rate_q;
  logic [7:0]         echo_cnt_d, echo_cnt_q;
  logic [7:0]         missed_d, missed_q;

  logic signed [33:0] range_diff;
  logic [31:0]        range_sat;
  logic               echo_exit;
  logic               miss;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    state_d    = state_q;
    dist_d     = dist_q;
    acc_d      = acc_q;
    wcnt_d     = wcnt_q;
    echo_d     = echo_q;
    range_d    = range_q;
    rate_d     = rate_q;
    echo_cnt_d = echo_cnt_q;
    missed_d   = missed_q;
    echo_exit  = 1'b0;
    miss       = 1'b0;

    // Range minus signed closing rate, clamped to 0 .. 2^32-1.
    range_diff = $signed({2'b00, range_q}) - $signed({{18{rate_q[15]}}, rate_q});
    if (range_diff < 0)           range_sat = '0;
    else if (range_diff[32])      range_sat = '1;
    else                          range_sat = range_diff[31:0];

    unique case (state_q)
      RESP_IDLE: begin
        if (rise) begin
          if (range_q > MAX_R) begin
            miss = 1'b1;
          end else begin
            state_d = RESP_FLIGHT;
            dist_d  = range_q;
            acc_d   = M_STEP;
          end
        end
      end
      RESP_FLIGHT: begin
        miss = rise;
        if (acc_q >= {1'b0, dist_q}) begin
          state_d = RESP_ECHO;
          echo_d  = 1'b1;
          wcnt_d  = '0;
        end else begin
          acc_d = acc_q + M_STEP;
        end
      end
      RESP_ECHO: begin
        if (wcnt_q == WCNT_LAST) begin
          echo_exit  = 1'b1;
          state_d    = RESP_IDLE;
          echo_d     = 1'b0;
          echo_cnt_d = echo_cnt_q + 8'd1;
          range_d    = range_sat;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
          miss   = rise;
        end
      end
      default: state_d = RESP_IDLE;
    endcase

    if (load_target) begin
      range_d = target_range;
      rate_d  = closing_rate;
    end

    // A trigger on the ECHO exit edge is accepted and flies with the updated range.
    if (echo_exit && rise) begin
      if (range_d > MAX_R) begin
        miss = 1'b1;
      end else begin
        state_d = RESP_FLIGHT;
        dist_d  = range_d;
        acc_d   = M_STEP;
      end
    end

    if (miss && (missed_q != 8'hFF)) missed_d = missed_q + 8'd1;

    busy_d = (state_d != RESP_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= RESP_IDLE;
      dist_q     <= '0;
      acc_q      <= '0;
      wcnt_q     <= '0;
      echo_q     <= 1'b0;
      busy_q     <= 1'b0;
      range_q    <= '0;
      rate_q     <= '0;
      echo_cnt_q <= '0;
      missed_q   <= '0;
    end else begin
      state_q    <= state_d;
      dist_q     <= dist_d;
      acc_q      <= acc_d;
      wcnt_q     <= wcnt_d;
      echo_q     <= echo_d;
      busy_q     <= busy_d;
      range_q    <= range_d;
      rate_q     <= rate_d;
      echo_cnt_q <= echo_cnt_d;
      missed_q   <= missed_d;
    end
  end

  assign radar_echo    = echo_q;
  assign busy          = busy_q;
  assign current_range = range_q;
  assign echo_count    = echo_cnt_q;
  assign missed_count  = missed_q;
  assign resp_state    = state_q;

endmodule

// File: tb/tb_radar_echo_responder.sv
// Scoreboard bench for radar_echo_responder: stimulus queues the expected echo
// timing and post-echo state; a negedge monitor pops and compares each echo.
module tb_radar_echo_responder;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        radar_pulse_trigger = 1'b0;
  logic        load_target = 1'b0;
  logic [31:0] target_range = '0;
  logic [15:0] closing_rate = '0;
  logic        radar_echo;
  logic        busy;
  logic [31:0] current_range;
  logic [7:0]  echo_count;
  logic [7:0]  missed_count;
  logic [1:0]  resp_state;

  radar_echo_responder dut (
    .CLK                 (CLK),
    .RST                 (RST),
    .radar_pulse_trigger (radar_pulse_trigger),
    .load_target         (load_target),
    .target_range        (target_range),
    .closing_rate        (closing_rate),
    .radar_echo          (radar_echo),
    .busy                (busy),
    .current_range       (current_range),
    .echo_count          (echo_count),
    .missed_count        (missed_count),
    .resp_state          (resp_state)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          rise;
    logic [31:0] range;
    logic [7:0]  cnt;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: echo rise cycle, echo width, then range/count right after the fall.
  initial begin
    logic echo_prev;
    logic in_echo;
    int   rise_cyc;
    exp_t cur;
    echo_prev = 1'b0;
    in_echo   = 1'b0;
    rise_cyc  = 0;
    forever begin
      @(negedge CLK);
      if (radar_echo && !echo_prev) begin
        if (sb.size() == 0) begin
          check("unexpected_echo", 1, 0);
        end else begin
          cur = sb.pop_front();
          check("echo_rise_cycle", cyc, cur.rise);
          rise_cyc = cyc;
          in_echo  = 1'b1;
        end
      end else if (!radar_echo && echo_prev && in_echo) begin
        in_echo = 1'b0;
        check("echo_width", cyc - rise_cyc, 2);
        check("range_after_echo", current_range, cur.range);
        check("echo_count_after_echo", echo_count, cur.cnt);
      end
      echo_prev = radar_echo;
    end
  end

  task automatic do_load(input logic [31:0] rng, input logic [15:0] rate);
    @(negedge CLK);
    load_target  = 1'b1;
    target_range = rng;
    closing_rate = rate;
    @(negedge CLK);
    load_target  = 1'b0;
  endtask

  // One-cycle trigger; expected echo N cycles after the sampled edge E0.
  task automatic pulse(input int n, input logic [31:0] rng_after, input logic [7:0] cnt_after);
    exp_t e;
    @(negedge CLK);
    radar_pulse_trigger = 1'b1;
    e.rise  = cyc + 1 + n;
    e.range = rng_after;
    e.cnt   = cnt_after;
    sb.push_back(e);
    @(negedge CLK);
    radar_pulse_trigger = 1'b0;
  endtask

  initial begin
    int k;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check("reset_state", resp_state, 0);
    check("reset_echo", radar_echo, 0);
    check("reset_busy", busy, 0);
    check("reset_range", current_range, 0);
    check("reset_echo_count", echo_count, 0);
    check("reset_missed_count", missed_count, 0);

    // Basic echo: range 20000 -> N=2.
    do_load(32'd20000, 16'd0);
    pulse(2, 32'd20000, 8'd1);
    check("flight_state", resp_state, 1);
    check("flight_busy", busy, 1);
    repeat (8) @(negedge CLK);

    // Delay boundaries.
    do_load(32'd0, 16'd0);      pulse(1, 32'd0, 8'd2);      repeat (8) @(negedge CLK);
    do_load(32'd15000, 16'd0);  pulse(1, 32'd15000, 8'd3);  repeat (8) @(negedge CLK);
    do_load(32'd15001, 16'd0);  pulse(2, 32'd15001, 8'd4);  repeat (8) @(negedge CLK);
    do_load(32'd45000, 16'd0);  pulse(3, 32'd45000, 8'd5);  repeat (8) @(negedge CLK);

    // Closing target, saturating at zero.
    do_load(32'd20000, 16'd7000);
    pulse(2, 32'd13000, 8'd6);  repeat (9) @(negedge CLK);
    pulse(1, 32'd6000, 8'd7);   repeat (9) @(negedge CLK);
    pulse(1, 32'd0, 8'd8);      repeat (9) @(negedge CLK);

    // Receding target loaded mid-flight, saturating at 2^32-1.
    do_load(32'd45000, 16'd0);
    pulse(3, 32'hFFFF_FFFF, 8'd9);
    do_load(32'hFFFF_EC78, 16'hE4A8);
    repeat (8) @(negedge CLK);
    check("no_miss_after_midflight_load", missed_count, 0);

    // Exactly MAX_RANGE still echoes; one metre more does not.
    do_load(32'd1000000, 16'd0);
    pulse(67, 32'd1000000, 8'd10);
    repeat (72) @(negedge CLK);
    do_load(32'd1000001, 16'd0);
    pulse(0, 32'd0, 8'd0);
    void'(sb.pop_back());
    check("out_of_range_state", resp_state, 0);
    check("out_of_range_busy", busy, 0);
    repeat (5) @(negedge CLK);
    check("out_of_range_missed", missed_count, 1);
    check("out_of_range_echo_count", echo_count, 10);

    // Held trigger plus a second rising edge during FLIGHT.
    do_load(32'd150000, 16'd0);
    begin
      exp_t e;
      @(negedge CLK);
      radar_pulse_trigger = 1'b1;
      e.rise  = cyc + 1 + 10;
      e.range = 32'd150000;
      e.cnt   = 8'd11;
      sb.push_back(e);
    end
    repeat (5) @(negedge CLK);
    radar_pulse_trigger = 1'b0;
    @(negedge CLK);
    radar_pulse_trigger = 1'b1;
    @(negedge CLK);
    radar_pulse_trigger = 1'b0;
    repeat (12) @(negedge CLK);
    check("held_trigger_missed", missed_count, 2);

    // Reset during FLIGHT, trigger held high across reset.
    do_load(32'd45000, 16'd0);
    @(negedge CLK);
    radar_pulse_trigger = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("abort_state", resp_state, 0);
    check("abort_echo", radar_echo, 0);
    check("abort_busy", busy, 0);
    check("abort_echo_count", echo_count, 0);
    check("abort_missed_count", missed_count, 0);
    check("abort_range", current_range, 0);
    @(negedge CLK);
    RST = 1'b0;
    begin
      exp_t e;
      e.rise  = cyc + 1 + 1;
      e.range = 32'd0;
      e.cnt   = 8'd1;
      sb.push_back(e);
    end
    repeat (6) @(negedge CLK);
    radar_pulse_trigger = 1'b0;
    repeat (3) @(negedge CLK);
    check("post_reset_missed", missed_count, 0);

    k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(negedge CLK);
      k++;
    end
    check("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=%0d expected=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
